// File: rtl/sd_pat_gen.sv
`default_nettype none
// ============================================================================
// Module   : sd_pat_gen
// Brief    : Service-data pattern generator; streams DP_COUNT packets of DP_LEN
//            bytes per service request over a valid/ready byte interface.
// Revision : 1.0  initial release
// ============================================================================
module sd_pat_gen #(
    parameter int unsigned             WORD_BYTES = 2,
    parameter int unsigned             DP_LEN     = 8,
    parameter int unsigned             DP_COUNT   = 4,
    parameter logic [8*WORD_BYTES-1:0] INI_VAL    = 16'hABCD,
    parameter logic [8*WORD_BYTES-1:0] LFSR_TAPS  = 16'hB400,
    parameter bit                      MSB_FIRST  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       service_req_i,
    input  logic [1:0] mode_i,
    input  logic       tx_en_i,
    input  logic       d_ready_i,
    output logic [7:0] d_o,
    output logic       d_valid_o,
    output logic       d_last_o,
    output logic       tx_rdy_o,
    output logic       has_next_dp_o,
    output logic [7:0] dp_remain_o,
    output logic       done_o
);

    localparam int                W         = 8 * WORD_BYTES;
    localparam int                IDX_W     = (DP_LEN > 1) ? $clog2(DP_LEN) : 1;
    localparam int                LANE_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DP_LEN - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
    localparam logic [1:0]        MODE_INC  = 2'b00;
    localparam logic [1:0]        MODE_LFSR = 2'b01;
    localparam logic [1:0]        MODE_CONST = 2'b10;
    localparam logic [1:0]        MODE_ROT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_EN = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         dp_remain_q, dp_remain_d;
    logic [W-1:0]       word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic               tx_en_q;
    logic               done_q, done_d;

    logic               tx_en_rise;
    logic [W-1:0]       word_seed;
    logic [W-1:0]       word_next;
    logic [7:0]         lane_byte;
    logic               sending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_INC;
            dp_remain_q <= 8'd0;
            word_q      <= INI_VAL;
            idx_q       <= '0;
            lane_q      <= '0;
            tx_en_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dp_remain_q <= dp_remain_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            tx_en_q     <= tx_en_i;
            done_q      <= done_d;
        end
    end

    assign tx_en_rise = tx_en_i & ~tx_en_q;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign word_seed = ((mode_q == MODE_LFSR) && (INI_VAL == '0)) ? W'(1) : INI_VAL;

    always_comb begin
        word_next = word_q;
        case (mode_q)
            MODE_INC:   word_next = word_q + W'(1);
            MODE_LFSR:  word_next = {1'b0, word_q[W-1:1]} ^ (word_q[0] ? LFSR_TAPS : '0);
            MODE_CONST: word_next = word_q;
            MODE_ROT:   word_next = {word_q[W-2:0], word_q[W-1]};
            default:    word_next = word_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dp_remain_d = dp_remain_q;
        word_d      = word_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        done_d      = 1'b0;

        if (service_req_i) begin
            // A request in any state (even on the final handshake) restarts.
            state_d     = WAIT_EN;
            mode_d      = mode_i;
            dp_remain_d = 8'(DP_COUNT);
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_EN: begin
                    if (tx_en_rise) begin
                        state_d = SEND;
                        word_d  = word_seed;
                        idx_d   = '0;
                        lane_d  = '0;
                    end
                end
                SEND: begin
                    if (!tx_en_i) begin
                        state_d = WAIT_EN;
                    end else if (d_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            dp_remain_d = dp_remain_q - 8'd1;
                            if (dp_remain_q > 8'd1) begin
                                state_d = WAIT_EN;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            if (lane_q == LAST_LANE) begin
                                lane_d = '0;
                                word_d = word_next;
                            end else begin
                                lane_d = lane_q + LANE_W'(1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        lane_byte = 8'h00;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (lane_q == LANE_W'(k)) begin
                lane_byte = MSB_FIRST ? word_q[W-1-8*k -: 8] : word_q[8*k +: 8];
            end
        end
    end

    assign sending       = (state_q == SEND);
    assign d_valid_o     = sending;
    assign d_o           = sending ? lane_byte : 8'h00;
    assign d_last_o      = sending && (idx_q == LAST_IDX);
    assign tx_rdy_o      = (state_q != IDLE);
    assign has_next_dp_o = (state_q != IDLE) && (dp_remain_q > 8'd1);
    assign dp_remain_o   = dp_remain_q;
    assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_pat_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_pat_gen
// Brief    : Self-checking bench; four generator variants driven in lockstep
//            and compared with a word-sequence reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_pat_gen;

    localparam int          NI       = 4;
    localparam int          DPL      = 8;
    localparam logic [63:0] SEED_TAB = {16'h0000, 16'h0001, 16'hFFFF, 16'hABCD};

    logic       clk;
    logic       rst_n;
    logic       service_req;
    logic [1:0] mode;
    logic       tx_en;
    logic       d_ready;

    logic [7:0] d_w         [NI];
    logic       d_valid_w   [NI];
    logic       d_last_w    [NI];
    logic       tx_rdy_w    [NI];
    logic       has_next_w  [NI];
    logic [7:0] dp_remain_w [NI];
    logic       done_w      [NI];

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    logic [7:0] cap_d [NI][DPL];
    logic       cap_l [NI][DPL];
    logic       cap_hn [NI];
    int         cap_timeout, cap_unstable, cap_bubbles, cap_cycles;
    logic       cap_first_valid;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sd_pat_gen #(
            .WORD_BYTES (2),
            .DP_LEN     (DPL),
            .DP_COUNT   (2),
            .INI_VAL    (SEED_TAB[16*g +: 16]),
            .LFSR_TAPS  (16'hB400),
            .MSB_FIRST  ((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .service_req_i (service_req),
            .mode_i        (mode),
            .tx_en_i       (tx_en),
            .d_ready_i     (d_ready),
            .d_o           (d_w[g]),
            .d_valid_o     (d_valid_w[g]),
            .d_last_o      (d_last_w[g]),
            .tx_rdy_o      (tx_rdy_w[g]),
            .has_next_dp_o (has_next_w[g]),
            .dp_remain_o   (dp_remain_w[g]),
            .done_o        (done_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done_w[0] === 1'b1) done_cnt <= done_cnt + 1;

    // Byte k of a packet: word k/2 of the seed's sequence, lane chosen by byte order.
    function automatic logic [7:0] model_byte(input int inst, input logic [1:0] m, input int k);
        logic [15:0] w;
        w = SEED_TAB[16*inst +: 16];
        if (m == 2'b01 && w == 16'h0000) w = 16'h0001;
        case (m)
            2'b00:   w = w + 16'(k / 2);
            2'b01:   for (int j = 0; j < k / 2; j++) w = (w >> 1) ^ (w[0] ? 16'hB400 : 16'h0000);
            2'b10:   ;
            default: for (int j = 0; j < k / 2; j++) w = {w[14:0], w[15]};
        endcase
        if (((k % 2) == 0) == (inst != 1)) return w[15:8];
        return w[7:0];
    endfunction

    task automatic req(input logic [1:0] m);
        @(negedge clk);
        service_req = 1'b1;
        mode        = m;
        @(negedge clk);
        service_req = 1'b0;
        mode        = ~m;
    endtask

    task automatic grant();
        @(negedge clk);
        tx_en = 1'b0;
        @(negedge clk);
        tx_en = 1'b1;
    endtask

    task automatic capture_packet(input int stall_pct, input int stall_at, input int stall_len,
                                  input bit req_last, input logic [1:0] req_mode);
        int         n, held;
        bit         stalled;
        logic [7:0] prev_d [NI];
        logic       prev_l [NI];
        n = 0; held = 0; stalled = 0;
        cap_timeout = 1; cap_unstable = 0; cap_bubbles = 0; cap_cycles = 0;
        cap_first_valid = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            cap_cycles++;
            if (cyc == 0) cap_first_valid = d_valid_w[0];
            if (d_valid_w[0] !== 1'b1) cap_bubbles++;
            for (int i = 0; i < NI; i++) begin
                if (d_valid_w[i] !== d_valid_w[0]) cap_unstable++;
                if (stalled && (d_w[i] !== prev_d[i] || d_last_w[i] !== prev_l[i])) cap_unstable++;
                prev_d[i] = d_w[i];
                prev_l[i] = d_last_w[i];
                if (n == 0) cap_hn[i] = has_next_w[i];
            end
            if (stall_at == n && held < stall_len) begin
                d_ready = 1'b0;
                held++;
            end else begin
                d_ready = ($urandom_range(99) >= stall_pct);
            end
            stalled = (d_valid_w[0] === 1'b1) && !d_ready;
            if (d_valid_w[0] === 1'b1 && d_ready) begin
                for (int i = 0; i < NI; i++) begin
                    cap_d[i][n] = d_w[i];
                    cap_l[i][n] = d_last_w[i];
                end
                n++;
                if (n == DPL) begin
                    if (req_last) begin
                        service_req = 1'b1;
                        mode        = req_mode;
                    end
                    cap_timeout = 0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({d_w[i], d_valid_w[i], d_last_w[i], tx_rdy_w[i], has_next_w[i], dp_remain_w[i], done_w[i]} !== 21'd0) begin
                n_err++;
                $display("FAIL reset inst%0d: d=%h v=%b last=%b rdy=%b hn=%b rem=%0d done=%b, need all 0",
                         i, d_w[i], d_valid_w[i], d_last_w[i], tx_rdy_w[i], has_next_w[i], dp_remain_w[i], done_w[i]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({d_w[i], d_valid_w[i], d_last_w[i], tx_rdy_w[i], has_next_w[i], dp_remain_w[i], done_w[i]} !== 21'd0) begin
                n_err++;
                $display("FAIL reset_idle inst%0d: d=%h v=%b rdy=%b rem=%0d done=%b, need all 0",
                         i, d_w[i], d_valid_w[i], tx_rdy_w[i], dp_remain_w[i], done_w[i]);
            end
        end
    endtask

    // Two full packets from WAIT_EN (requested here or by the caller) through done.
    task automatic test_mode_sequence(input logic [1:0] m, input int stall_pct, input bit do_req);
        int done0;
        if (do_req) req(m);
        done0 = done_cnt;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (tx_rdy_w[i] !== 1'b1 || dp_remain_w[i] !== 8'd2 || d_valid_w[i] !== 1'b0 || has_next_w[i] !== 1'b1) begin
                n_err++;
                $display("FAIL seq_pre inst%0d mode%0d: rdy=%b rem=%0d v=%b hn=%b, need 1 2 0 1",
                         i, m, tx_rdy_w[i], dp_remain_w[i], d_valid_w[i], has_next_w[i]);
            end
        end
        for (int p = 0; p < 2; p++) begin
            grant();
            capture_packet(stall_pct, -1, 0, 1'b0, 2'b00);
            n_vec++;
            if (cap_timeout != 0 || cap_first_valid !== 1'b1 || cap_bubbles != 0 || cap_unstable != 0) begin
                n_err++;
                $display("FAIL seq_handshake mode%0d pkt%0d: timeout=%0d first_valid=%b bubbles=%0d unstable=%0d, need 0 1 0 0",
                         m, p, cap_timeout, cap_first_valid, cap_bubbles, cap_unstable);
            end
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < DPL; k++) begin
                    n_vec++;
                    if (cap_d[i][k] !== model_byte(i, m, k) || cap_l[i][k] !== (k == DPL - 1)) begin
                        n_err++;
                        $display("FAIL seq_byte inst%0d mode%0d pkt%0d byte%0d: got %h last=%b, need %h last=%b",
                                 i, m, p, k, cap_d[i][k], cap_l[i][k], model_byte(i, m, k), (k == DPL - 1));
                    end
                end
                n_vec++;
                if (cap_hn[i] !== (p == 0)) begin
                    n_err++;
                    $display("FAIL seq_has_next inst%0d pkt%0d: got %b, need %b", i, p, cap_hn[i], (p == 0));
                end
            end
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                n_vec++;
                if (dp_remain_w[i] !== 8'(1 - p) || d_valid_w[i] !== 1'b0 || tx_rdy_w[i] !== (p == 0) || done_w[i] !== (p == 1)) begin
                    n_err++;
                    $display("FAIL seq_post inst%0d pkt%0d: rem=%0d v=%b rdy=%b done=%b, need %0d 0 %b %b",
                             i, p, dp_remain_w[i], d_valid_w[i], tx_rdy_w[i], done_w[i], 1 - p, (p == 0), (p == 1));
                end
            end
            if (p == 0) begin
                repeat (2) @(negedge clk);
                n_vec++;
                if (d_valid_w[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL seq_stale_grant: d_valid=%b with tx_en held high, need 0", d_valid_w[0]);
                end
            end
        end
        tx_en = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (done_cnt - done0 != 1 || done_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL seq_done_pulse mode%0d: pulses=%0d done_now=%b, need 1 0", m, done_cnt - done0, done_w[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] m;
        m = 2'($urandom_range(3));
        req(m);
        grant();
        capture_packet(0, 3, 3, 1'b0, 2'b00);
        n_vec++;
        if (cap_timeout != 0 || cap_unstable != 0 || cap_cycles != DPL + 3) begin
            n_err++;
            $display("FAIL bp_stall mode%0d: timeout=%0d unstable=%0d cycles=%0d, need 0 0 %0d",
                     m, cap_timeout, cap_unstable, cap_cycles, DPL + 3);
        end
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < DPL; k++) begin
                n_vec++;
                if (cap_d[i][k] !== model_byte(i, m, k)) begin
                    n_err++;
                    $display("FAIL bp_byte inst%0d byte%0d: got %h, need %h", i, k, cap_d[i][k], model_byte(i, m, k));
                end
            end
        end
        @(negedge clk);
        grant();
        capture_packet(50, -1, 0, 1'b0, 2'b00);
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < DPL; k++) begin
                n_vec++;
                if (cap_d[i][k] !== model_byte(i, m, k) || cap_unstable != 0) begin
                    n_err++;
                    $display("FAIL bp_rand_byte inst%0d byte%0d: got %h unstable=%0d, need %h 0",
                             i, k, cap_d[i][k], cap_unstable, model_byte(i, m, k));
                end
            end
        end
        @(negedge clk);
        n_vec++;
        if (done_w[0] !== 1'b1 || tx_rdy_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_done: done=%b rdy=%b, need 1 0", done_w[0], tx_rdy_w[0]);
        end
        tx_en = 1'b0;
    endtask

    task automatic test_abort();
        req(2'b00);
        grant();
        d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (d_valid_w[0] !== 1'b1 || d_w[0] !== model_byte(0, 2'b00, k)) begin
                n_err++;
                $display("FAIL abort_pre byte%0d: v=%b d=%h, need 1 %h", k, d_valid_w[0], d_w[0], model_byte(0, 2'b00, k));
            end
        end
        @(negedge clk);
        d_ready = 1'b0;
        tx_en   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (d_valid_w[i] !== 1'b0 || dp_remain_w[i] !== 8'd2 || tx_rdy_w[i] !== 1'b1) begin
                n_err++;
                $display("FAIL abort_drop inst%0d: v=%b rem=%0d rdy=%b, need 0 2 1", i, d_valid_w[i], dp_remain_w[i], tx_rdy_w[i]);
            end
        end
        test_mode_sequence(2'b00, 0, 1'b0);
    endtask

    task automatic test_restart();
        int done0;
        req(2'b00);
        done0 = done_cnt;
        grant();
        capture_packet(0, -1, 0, 1'b0, 2'b00);
        @(negedge clk);
        grant();
        d_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        service_req = 1'b1;
        mode        = 2'b10;
        @(negedge clk);
        service_req = 1'b0;
        mode        = 2'b00;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (d_valid_w[i] !== 1'b0 || dp_remain_w[i] !== 8'd2 || tx_rdy_w[i] !== 1'b1 || done_w[i] !== 1'b0) begin
                n_err++;
                $display("FAIL restart inst%0d: v=%b rem=%0d rdy=%b done=%b, need 0 2 1 0",
                         i, d_valid_w[i], dp_remain_w[i], tx_rdy_w[i], done_w[i]);
            end
        end
        n_vec++;
        if (done_cnt != done0) begin
            n_err++;
            $display("FAIL restart_no_done: pulses=%0d, need 0", done_cnt - done0);
        end
        test_mode_sequence(2'b10, 0, 1'b0);
    endtask

    task automatic test_req_on_last();
        req(2'b11);
        grant();
        capture_packet(0, -1, 0, 1'b0, 2'b00);
        @(negedge clk);
        grant();
        capture_packet(0, -1, 0, 1'b1, 2'b01);
        @(negedge clk);
        service_req = 1'b0;
        mode        = 2'b10;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (done_w[i] !== 1'b0 || tx_rdy_w[i] !== 1'b1 || dp_remain_w[i] !== 8'd2) begin
                n_err++;
                $display("FAIL req_on_last inst%0d: done=%b rdy=%b rem=%0d, need 0 1 2",
                         i, done_w[i], tx_rdy_w[i], dp_remain_w[i]);
            end
        end
        test_mode_sequence(2'b01, 20, 1'b0);
    endtask

    task automatic test_async_reset();
        req(2'($urandom_range(3)));
        grant();
        d_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({d_w[i], d_valid_w[i], d_last_w[i], tx_rdy_w[i], has_next_w[i], dp_remain_w[i], done_w[i]} !== 21'd0) begin
                n_err++;
                $display("FAIL async_reset inst%0d: d=%h v=%b rdy=%b rem=%0d, need all 0",
                         i, d_w[i], d_valid_w[i], tx_rdy_w[i], dp_remain_w[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tx_en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (tx_rdy_w[0] !== 1'b0 || d_valid_w[0] !== 1'b0 || dp_remain_w[0] !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset_idle: rdy=%b v=%b rem=%0d, need 0 0 0", tx_rdy_w[0], d_valid_w[0], dp_remain_w[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        service_req = 1'b0;
        mode        = 2'b00;
        tx_en       = 1'b0;
        d_ready     = 1'b0;
        test_reset();
        test_mode_sequence(2'b00, 0, 1'b1);
        test_mode_sequence(2'b01, 0, 1'b1);
        test_mode_sequence(2'b11, 0, 1'b1);
        test_mode_sequence(2'b10, 0, 1'b1);
        test_backpressure();
        test_abort();
        test_restart();
        test_req_on_last();
        test_async_reset();
        for (int r = 0; r < 6; r++) test_mode_sequence(2'($urandom_range(3)), 40, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_pat_gen.md
Name: sd_pat_gen

Overview:
- Parametrised service-data pattern generator. On a service request it sources DP_COUNT data packets of DP_LEN bytes each, one byte per valid/ready handshake, toward the HSI transmit path.
- Generalises the fixed 16-bit incrementing service-data source:
  - configurable word width, packet length and packet count;
  - selectable pattern modes and byte order;
  - fully synchronous to clk, with no derived clocks.

Parameters:
- WORD_BYTES, 2: bytes per pattern word; W = 8*WORD_BYTES.
- DP_LEN, 8: bytes per data packet; must be a multiple of WORD_BYTES and at least WORD_BYTES.
- DP_COUNT, 4: packets per service request, range 1..255.
- INI_VAL, 16'hABCD: pattern seed, W bits wide.
- LFSR_TAPS, 16'hB400: Galois LFSR feedback mask, W bits wide.
- MSB_FIRST, 1: 1 = most significant byte of each word sent first; 0 = least significant byte first.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- service_req  in  1  single-cycle pulse; starts or restarts a sequence.
- mode  in  2  pattern select: 00 incrementing, 01 LFSR, 10 constant, 11 walking rotate. Sampled on service_req.
- tx_en  in  1  downstream packet grant; must stay high for the whole packet.
- d_ready  in  1  consumer accepts the byte on d.
- d  out  8  data byte.
- d_valid  out  1  d holds a valid byte.
- d_last  out  1  d is the final byte of the current packet.
- tx_rdy  out  1  generator has packets pending (state is not IDLE).
- has_next_dp  out  1  at least one more packet follows the current one.
- dp_remain  out  8  packets not yet completed.
- done  out  1  one-cycle pulse after the last byte of the last packet.

Behaviour:
- Reset values: all outputs 0; state IDLE; word register = INI_VAL; dp_remain = 0.
- State machine: IDLE, WAIT_EN, SEND.
  - IDLE → WAIT_EN on service_req.
    - Latch mode; load dp_remain = DP_COUNT.
    - tx_rdy goes high the cycle after service_req.
  - WAIT_EN → SEND on a rising edge of tx_en (tx_en registered low last cycle, high this cycle).
    - Load word = INI_VAL (pattern restarts every packet); clear the byte index.
    - d_valid goes high the next cycle with the first byte.
    - A tx_en that is already high on entry to WAIT_EN does not start a packet; it must fall and rise again.
  - SEND: each cycle with d_valid & d_ready advances the byte index.
    - Crossing a word boundary advances the word.
    - No bubbles: the next byte is valid the following cycle.
    - While d_valid & ~d_ready, d and d_last hold stable.
  - Last-byte handshake: d_last is high with byte DP_LEN-1.
    - dp_remain decrements on that handshake.
    - Next state is WAIT_EN if dp_remain > 0 after the decrement.
    - Otherwise next state is IDLE: done pulses, tx_rdy falls.
- Byte order: byte k within a word is bits [W-1-8k -: 8] when MSB_FIRST=1, else [8k +: 8].
- Word advance per mode (all arithmetic modulo 2^W):
  - 00 incrementing: word + 1, wrapping to 0.
  - 01 LFSR: one Galois step, shift right, XOR LFSR_TAPS when the LSB is 1. A zero seed is forced to 1.
  - 10 constant: word unchanged.
  - 11 walking rotate: rotate left by 1.
- has_next_dp = (dp_remain > 1) while not IDLE; 0 in IDLE.
- tx_en falls during SEND:
  - Abort the packet: d_valid drops the next cycle; return to WAIT_EN.
  - dp_remain is unchanged; the packet is resent from INI_VAL on the next grant.
- service_req outside IDLE:
  - Restart: go to WAIT_EN, reload dp_remain = DP_COUNT, relatch mode, drop d_valid.
  - No done pulse.
- service_req in the same cycle as the final handshake: restart wins; no done pulse.
- Asynchronous reset mid-packet: all outputs clear immediately; state IDLE.
- Counter widths: byte index is clog2(DP_LEN) bits; dp_remain is 8 bits.

Test Plan:
- Reset defaults, mode 00, DP_COUNT=2.
  - Stimulus: service_req, tx_en rise, d_ready held high.
  - Required: bytes AB CD AB CE AB CF AB D0 with d_last on D0; has_next_dp=1 during the first packet; second packet repeats AB CD …; done pulses once; tx_rdy then 0.
- MSB_FIRST=0, INI_VAL=16'hFFFF, mode 00.
  - Required: FF FF 00 00 01 00 02 00 (wrap to 0).
- Mode 01, INI_VAL=16'h0001.
  - Required: second word 16'hB400, sent as B4 00; INI_VAL=0 gives first word 16'h0001.
- Backpressure: toggle d_ready low for 3 cycles at byte 3.
  - Required: d and d_last stable while stalled; no byte skipped or duplicated.
- Abort: drop tx_en after byte 2 of packet 1.
  - Required: d_valid low the next cycle; dp_remain stays 2; the re-grant resends from AB CD.
- service_req mid-packet 2 with mode changed to 10.
  - Required: return to WAIT_EN; dp_remain = DP_COUNT; next packet is AB CD AB CD AB CD AB CD; no done pulse.
